// File: rtl/nunchuk_pkg.sv
// Shared types and constants for the Nunchuk poller: FSM states, init/convert
// command bytes, and the bit layout of the sixth packet byte.
package nunchuk_pkg;

  typedef enum logic [2:0] {
    INIT_A, INIT_B, IDLE, CONV, SETTLE, READ, DECODE, ERR_WAIT
  } nk_state_e;

  localparam logic [7:0] INIT_A_REG = 8'hF0;
  localparam logic [7:0] INIT_A_VAL = 8'h55;
  localparam logic [7:0] INIT_B_REG = 8'hFB;
  localparam logic [7:0] INIT_B_VAL = 8'h00;
  localparam logic [7:0] CONV_BYTE  = 8'h00;

  // b5 packs the button bits and the two LSBs of each accelerometer axis
  localparam int B5_Z  = 0;
  localparam int B5_C  = 1;
  localparam int B5_AX = 2;
  localparam int B5_AY = 4;
  localparam int B5_AZ = 6;

  typedef struct packed {
    logic [7:0] stick_x;
    logic [7:0] stick_y;
    logic [9:0] accel_x;
    logic [9:0] accel_y;
    logic [9:0] accel_z;
    logic       z;
    logic       c;
  } nk_fields_t;

  localparam nk_fields_t FIELDS_RST = '{
    stick_x: 8'd128, stick_y: 8'd128,
    accel_x: 10'd512, accel_y: 10'd512, accel_z: 10'd512,
    z: 1'b0, c: 1'b0
  };

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nunchuk_packet_decode.sv
// Combinational unpack of the 6-byte report (b0 in the top byte) into fields,
// plus the all-FF flag that marks a disconnected controller.
module nunchuk_packet_decode
  import nunchuk_pkg::*;
(
  input  logic [47:0] pkt,
  output nk_fields_t  fields,
  output logic        all_ff
);

  logic [7:0] b0, b1, b2, b3, b4, b5;

  assign {b0, b1, b2, b3, b4, b5} = pkt;

  always_comb begin
    fields         = FIELDS_RST;
    fields.stick_x = b0;
    fields.stick_y = b1;
    fields.accel_x = {b2, b5[B5_AX +: 2]};
    fields.accel_y = {b3, b5[B5_AY +: 2]};
    fields.accel_z = {b4, b5[B5_AZ +: 2]};
    // buttons are active-low on the wire
    fields.z       = ~b5[B5_Z];
    fields.c       = ~b5[B5_C];
  end

  assign all_ff = &pkt;

endmodule

// File: rtl/nunchuk_poller.sv
// Periodic Nunchuk poller: init handshake, conversion write, settle, 6-byte
// read burst and decode, driven through a one-byte-at-a-time I2C engine.
module nunchuk_poller
  import nunchuk_pkg::*;
#(
  parameter int POLL_CYCLES   = 833333,
  parameter int SETTLE_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_start,
  output logic       cmd_stop,
  output logic       cmd_read,
  output logic       cmd_nack,
  output logic [7:0] cmd_wdata,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_rdata,
  input  logic       rsp_err,
  output logic [7:0] stick_X,
  output logic [7:0] stick_Y,
  output logic [9:0] accel_X,
  output logic [9:0] accel_Y,
  output logic [9:0] accel_Z,
  output logic       z,
  output logic       c,
  output logic       data_valid,
  output logic       link_ok
);

  localparam int PW = cnt_w(POLL_CYCLES);
  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  nk_state_e   state;
  logic [2:0]  byte_idx;
  logic        busy;
  logic [47:0] pkt;
  logic [PW-1:0] poll_cnt;
  logic [SW-1:0] settle_cnt;
  nk_fields_t  fld, dec_fields;
  logic        dec_all_ff;

  logic       issue, nx_start, nx_stop, nx_read, nx_nack;
  logic [7:0] nx_wdata;

  nunchuk_packet_decode u_dec (
    .pkt    (pkt),
    .fields (dec_fields),
    .all_ff (dec_all_ff)
  );

  assign stick_X = fld.stick_x;
  assign stick_Y = fld.stick_y;
  assign accel_X = fld.accel_x;
  assign accel_Y = fld.accel_y;
  assign accel_Z = fld.accel_z;
  assign z       = fld.z;
  assign c       = fld.c;

  // payload of the next byte for the current state and position
  always_comb begin
    issue    = 1'b0;
    nx_start = 1'b0;
    nx_stop  = 1'b0;
    nx_read  = 1'b0;
    nx_nack  = 1'b0;
    nx_wdata = 8'h00;
    case (state)
      INIT_A: begin
        issue    = 1'b1;
        nx_start = (byte_idx == 3'd0);
        nx_stop  = (byte_idx != 3'd0);
        nx_wdata = (byte_idx == 3'd0) ? INIT_A_REG : INIT_A_VAL;
      end
      INIT_B: begin
        issue    = 1'b1;
        nx_start = (byte_idx == 3'd0);
        nx_stop  = (byte_idx != 3'd0);
        nx_wdata = (byte_idx == 3'd0) ? INIT_B_REG : INIT_B_VAL;
      end
      CONV: begin
        issue    = 1'b1;
        nx_start = 1'b1;
        nx_stop  = 1'b1;
        nx_wdata = CONV_BYTE;
      end
      READ: begin
        issue    = 1'b1;
        nx_read  = 1'b1;
        nx_start = (byte_idx == 3'd0);
        nx_stop  = (byte_idx == 3'd5);
        nx_nack  = (byte_idx == 3'd5);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT_A;
      byte_idx   <= 3'd0;
      busy       <= 1'b0;
      pkt        <= '0;
      poll_cnt   <= '0;
      settle_cnt <= '0;
      fld        <= FIELDS_RST;
      cmd_valid  <= 1'b0;
      cmd_start  <= 1'b0;
      cmd_stop   <= 1'b0;
      cmd_read   <= 1'b0;
      cmd_nack   <= 1'b0;
      cmd_wdata  <= 8'h00;
      data_valid <= 1'b0;
      link_ok    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (poll_cnt != POLL_LAST) poll_cnt <= poll_cnt + 1'b1;

      // payload registers only move when a new byte is offered
      if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
        busy      <= 1'b1;
      end else if (issue && !cmd_valid && !busy) begin
        cmd_valid <= 1'b1;
        cmd_start <= nx_start;
        cmd_stop  <= nx_stop;
        cmd_read  <= nx_read;
        cmd_nack  <= nx_nack;
        cmd_wdata <= nx_wdata;
      end

      case (state)
        INIT_A, INIT_B, CONV, READ: begin
          if (busy && rsp_valid) begin
            busy     <= 1'b0;
            byte_idx <= byte_idx + 3'd1;
            if (rsp_err && !cmd_read) begin
              state    <= ERR_WAIT;
              link_ok  <= 1'b0;
              poll_cnt <= '0;
              byte_idx <= 3'd0;
            end else begin
              case (state)
                INIT_A: if (byte_idx == 3'd1) begin
                  state    <= INIT_B;
                  byte_idx <= 3'd0;
                end
                INIT_B: if (byte_idx == 3'd1) begin
                  state    <= CONV;
                  byte_idx <= 3'd0;
                  poll_cnt <= '0;
                end
                CONV: begin
                  state      <= SETTLE;
                  byte_idx   <= 3'd0;
                  settle_cnt <= '0;
                end
                default: begin
                  pkt <= {pkt[39:0], rsp_rdata};
                  if (byte_idx == 3'd5) begin
                    state    <= DECODE;
                    byte_idx <= 3'd0;
                  end
                end
              endcase
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= READ;
          else settle_cnt <= settle_cnt + 1'b1;
        end
        DECODE: begin
          if (dec_all_ff) begin
            link_ok <= 1'b0;
            state   <= INIT_A;
          end else begin
            fld        <= dec_fields;
            data_valid <= 1'b1;
            link_ok    <= 1'b1;
            state      <= IDLE;
          end
        end
        IDLE: begin
          if (poll_cnt == POLL_LAST) begin
            state    <= CONV;
            poll_cnt <= '0;
          end
        end
        ERR_WAIT: begin
          if (poll_cnt == POLL_LAST) state <= INIT_A;
        end
        default: state <= INIT_A;
      endcase
    end
  end

endmodule

// File: tb/tb_nunchuk_poller.sv
// Scoreboard bench: expected commands and packets are queued with the stimulus
// and retired by a byte-engine responder and a data_valid monitor.
module tb_nunchuk_poller;
  localparam int POLL   = 1000;
  localparam int SETTLE = 20;
  localparam int LAT    = 3;
  localparam logic [47:0] RST_F   = {8'd128, 8'd128, 10'd512, 10'd512, 10'd512, 1'b0, 1'b0};
  localparam logic [47:0] P1      = 48'h807FAA55C0B4;
  localparam logic [47:0] P1_EXP  = {8'h80, 8'h7F, 10'h2A9, 10'h157, 10'h302, 1'b1, 1'b1};
  localparam logic [47:0] P2      = 48'h123456789A03;
  localparam logic [47:0] P3      = 48'h01FE1020300E;
  localparam logic [47:0] PFF     = 48'hFFFFFFFFFFFF;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid, cmd_ready = 1'b0, cmd_start, cmd_stop, cmd_read, cmd_nack;
  logic [7:0] cmd_wdata;
  logic rsp_valid = 1'b0, rsp_err = 1'b0;
  logic [7:0] rsp_rdata = 8'h00;
  logic [7:0] stick_X, stick_Y;
  logic [9:0] accel_X, accel_Y, accel_Z;
  logic z, c, data_valid, link_ok;
  logic [47:0] obs_f;
  logic [11:0] cmd_now;

  int checks = 0, errors = 0, cyc = 0;
  logic [11:0] exp_cmd[$];
  logic [7:0]  rd_q[$];
  logic [47:0] exp_pkt[$];
  int dv_cyc[$];
  int acc_cnt = 0, acc_cyc = 0, rd_done = 0, dv_cnt = 0, resp_cnt = 0;
  logic [7:0] err_byte = 8'h00, pend_data = 8'h00;
  logic err_arm = 1'b0, pend_err = 1'b0;

  nunchuk_poller #(.POLL_CYCLES(POLL), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_read(cmd_read), .cmd_nack(cmd_nack),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .stick_X(stick_X), .stick_Y(stick_Y),
    .accel_X(accel_X), .accel_Y(accel_Y), .accel_Z(accel_Z),
    .z(z), .c(c), .data_valid(data_valid), .link_ok(link_ok)
  );

  assign obs_f   = {stick_X, stick_Y, accel_X, accel_Y, accel_Z, z, c};
  assign cmd_now = {cmd_start, cmd_stop, cmd_read, cmd_nack, cmd_wdata};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] mk(input logic s, input logic p, input logic r,
                                     input logic n, input logic [7:0] d);
    return {s, p, r, n, d};
  endfunction

  function automatic logic [47:0] model(input logic [47:0] p);
    logic [7:0] b[6];
    for (int i = 0; i < 6; i++) b[i] = p[47-8*i -: 8];
    return {b[0], b[1], b[2], b[5][3:2], b[3], b[5][5:4], b[4], b[5][7:6], ~b[5][0], ~b[5][1]};
  endfunction

  task automatic push_init();
    exp_cmd.push_back(mk(1, 0, 0, 0, 8'hF0));
    exp_cmd.push_back(mk(0, 1, 0, 0, 8'h55));
    exp_cmd.push_back(mk(1, 0, 0, 0, 8'hFB));
    exp_cmd.push_back(mk(0, 1, 0, 0, 8'h00));
  endtask

  task automatic push_poll(input logic [47:0] p);
    exp_cmd.push_back(mk(1, 1, 0, 0, 8'h00));
    for (int i = 0; i < 6; i++) begin
      exp_cmd.push_back(mk(i == 0, i == 5, 1, i == 5, 8'h00));
      rd_q.push_back(p[47-8*i -: 8]);
    end
  endtask

  task automatic wait_cycles_until_acc(input int target, input int bound);
    for (int n = 0; n < bound && acc_cnt < target; n++) @(posedge clk);
    #1;
  endtask

  task automatic wait_dv(input int target, input int bound);
    for (int n = 0; n < bound && dv_cnt < target; n++) @(posedge clk);
    #1;
    chk("dv_seen", dv_cnt, target);
  endtask

  // byte engine: accepts on valid&&ready, answers LAT cycles later
  initial forever begin
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    if (!rst_n) resp_cnt = 0;
    else begin
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_rdata = pend_data;
          rsp_err   = pend_err;
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd.size() == 0) chk("cmd_expected", exp_cmd.size(), 1);
        else chk("cmd", cmd_now, exp_cmd.pop_front());
        acc_cnt++;
        acc_cyc  = cyc;
        pend_err = err_arm && !cmd_read && (cmd_wdata == err_byte);
        if (pend_err) err_arm = 1'b0;
        pend_data = 8'h00;
        if (cmd_read) begin
          if (rd_q.size() > 0) pend_data = rd_q.pop_front();
          rd_done++;
        end
        resp_cnt = LAT;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && data_valid) begin
      dv_cnt++;
      dv_cyc.push_back(cyc);
      if (exp_pkt.size() == 0) chk("dv_expected", exp_pkt.size(), 1);
      else chk("fields", obs_f, exp_pkt.pop_front());
      chk("link_ok_dv", link_ok, 1);
    end
  end

  initial begin
    int base, c55, bad;
    logic [11:0] snap;
    cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_link_ok", link_ok, 0);
    chk("rst_fields", obs_f, RST_F);

    // good packet, then a second poll to measure the period
    push_init();
    push_poll(P1);
    exp_pkt.push_back(P1_EXP);
    push_poll(P2);
    exp_pkt.push_back(model(P2));
    rst_n = 1'b1;
    wait_dv(1, 500);
    wait_dv(2, 1500);
    chk("dv_period", (dv_cyc.size() >= 2) ? dv_cyc[1] - dv_cyc[0] : 0, POLL);

    // disconnected packet, then re-init and a fresh good packet
    base = rd_done;
    push_poll(PFF);
    push_init();
    push_poll(P3);
    exp_pkt.push_back(model(P3));
    for (int n = 0; n < 1500 && rd_done < base + 6; n++) @(posedge clk);
    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("disc_link_ok", link_ok, 0);
    chk("disc_fields_hold", obs_f, model(P2));
    chk("disc_no_dv", dv_cnt, 2);
    wait_dv(3, 500);

    // slave NACK on the 55 init byte
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_cmd.delete();
    rd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst2_fields", obs_f, RST_F);
    err_byte = 8'h55;
    err_arm  = 1'b1;
    exp_cmd.push_back(mk(1, 0, 0, 0, 8'hF0));
    exp_cmd.push_back(mk(0, 1, 0, 0, 8'h55));
    base = acc_cnt;
    rst_n = 1'b1;
    wait_cycles_until_acc(base + 2, 100);
    c55 = acc_cyc;
    push_init();
    push_poll(P2);
    exp_pkt.push_back(model(P2));
    wait_cycles_until_acc(base + 3, 1200);
    chk("err_restart_seen", acc_cnt, base + 3);
    chk("err_gap_min", (acc_cyc - c55) >= POLL, 1);
    chk("err_gap_max", (acc_cyc - c55) <= POLL + 10, 1);
    chk("err_link_ok", link_ok, 0);
    chk("err_fields", obs_f, RST_F);
    wait_dv(4, 500);

    // stall the engine on read byte 3, then reset in the middle of READ
    base = acc_cnt;
    push_poll(P1);
    wait_cycles_until_acc(base + 4, 1500);
    cmd_ready = 1'b0;
    for (int n = 0; n < 20 && !cmd_valid; n++) @(negedge clk);
    @(negedge clk);
    chk("stall_valid", cmd_valid, 1);
    snap = cmd_now;
    chk("stall_payload", snap, mk(0, 0, 1, 0, 8'h00));
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!cmd_valid || cmd_now !== snap) bad++;
    end
    chk("stall_stable", bad, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_cmd.delete();
    rd_q.delete();
    #1;
    chk("async_rst_valid", cmd_valid, 0);
    chk("async_rst_fields", obs_f, RST_F);
    chk("async_rst_link", link_ok, 0);
    repeat (2) @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    exp_cmd.push_back(mk(1, 0, 0, 0, 8'hF0));
    base = acc_cnt;
    rst_n = 1'b1;
    wait_cycles_until_acc(base + 1, 20);
    cmd_ready = 1'b0;
    chk("post_rst_first_cmd", acc_cnt, base + 1);
    repeat (5) @(posedge clk);
    #1;
    chk("dv_total", dv_cnt, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nunchuk_poller.md
NUNCHUK_POLLER -- requirements
Module: nunchuk_poller

Interface
REQ-001 SHALL have parameter POLL_CYCLES, default 833333, meaning clk cycles from one poll start to the next (60 Hz at 50 MHz).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 10000, meaning wait between the conversion write and the read burst.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports cmd_valid, output, 1, and cmd_ready, input, 1: byte-command handshake to the I2C byte engine.
REQ-006 SHALL have ports cmd_start, cmd_stop, cmd_read and cmd_nack, each output, 1, meaning: START+address before the byte, STOP after it, read (not write) byte, NACK the read byte.
REQ-007 SHALL have port cmd_wdata, output, 8, write byte.
REQ-008 SHALL have ports rsp_valid, input, 1 (one-cycle byte-done pulse), rsp_rdata, input, 8, and rsp_err, input, 1 (slave NACK, qualified by rsp_valid).
REQ-009 SHALL have outputs stick_X and stick_Y, 8 each; accel_X, accel_Y and accel_Z, 10 each; z and c, 1 each, active-high buttons.
REQ-010 SHALL have outputs data_valid, 1 (one-cycle pulse on each field update), and link_ok, 1 (controller responding).

Function
REQ-011 SHALL implement states INIT_A, INIT_B, IDLE, CONV, SETTLE, READ, DECODE, ERR_WAIT.
REQ-012 INIT_A SHALL send bytes F0 (start) then 55 (stop); INIT_B SHALL send FB (start) then 00 (stop); then go to CONV.
REQ-013 CONV SHALL send byte 00 with start and stop, then go to SETTLE; SETTLE SHALL count SETTLE_CYCLES, then go to READ.
REQ-014 READ SHALL issue 6 read bytes: byte 0 with cmd_start, byte 5 with cmd_nack and cmd_stop, bytes 1-4 with neither; READ SHALL then go to DECODE.
REQ-015 DECODE SHALL last exactly one cycle, then go to IDLE; IDLE SHALL wait until the poll counter, started at CONV entry, reaches POLL_CYCLES-1, then go to CONV.
REQ-016 cmd_valid and all cmd_* payload SHALL stay stable from assertion until the cycle cmd_valid&&cmd_ready; only one byte SHALL be outstanding; the next cmd_valid SHALL follow the rsp_valid of the prior byte, no earlier than the next cycle.
REQ-017 rsp_valid SHALL be ignored when no byte is outstanding.
REQ-018 rsp_valid with rsp_err on any write byte SHALL abort the sequence and go to ERR_WAIT; no further bytes SHALL be sent in that transaction; link_ok SHALL clear.
REQ-019 ERR_WAIT SHALL count POLL_CYCLES, then go to INIT_A.
REQ-020 Decode, with bytes b0-b5 in arrival order: stick_X=b0, stick_Y=b1, accel_X={b2,b5[3:2]}, accel_Y={b3,b5[5:4]}, accel_Z={b4,b5[7:6]}, z=~b5[0], c=~b5[1].
REQ-021 Fields, data_valid and link_ok SHALL change only on the DECODE cycle: outputs update, data_valid=1, link_ok=1; at all other times the fields SHALL hold.
REQ-022 A packet of all six bytes FF SHALL be treated as disconnected: fields unchanged, no data_valid, link_ok=0, next state INIT_A.
REQ-023 Counters SHALL be sized by $clog2 of their parameter and SHALL saturate, never wrap.

Reset
REQ-024 On rst_n low the block SHALL reset immediately, regardless of clk: state INIT_A; cmd_valid=0; data_valid=0; link_ok=0; stick_X=stick_Y=128; accel_X=accel_Y=accel_Z=512; z=c=0; counters 0.
REQ-025 Reset mid-transaction SHALL drop the outstanding byte; after release, the first command SHALL be F0 with start.

Structure
REQ-026 Package nunchuk_pkg SHALL hold the state enum, the init byte constants (F0, 55, FB, 00) and the b5 bit-field positions.
REQ-027 Decode SHALL be in sub-module nunchuk_packet_decode: combinational, 48-bit packet to fields plus all-FF flag.

Verification
REQ-028 After reset with cmd_ready=1 and a responder giving ACK, command sequence SHALL be exactly F0(s), 55(p), FB(s), 00(p), 00(s,p), then 6 reads with start on the first and nack+stop on the last.
REQ-029 Read bytes 80,7F,AA,55,C0,B4 SHALL yield one data_valid pulse with stick_X=0x80, stick_Y=0x7F, accel_X=0x2A9, accel_Y=0x157, accel_Z=0x302, z=1, c=1, link_ok=1.
REQ-030 rsp_err on byte 55 SHALL give no further command for POLL_CYCLES cycles, then F0(s); link_ok=0 and fields stay at reset values.
REQ-031 Packet FF x6 following a good packet SHALL hold the prior fields, produce no data_valid, clear link_ok, and restart at INIT_A.
REQ-032 With cmd_ready held low 20 cycles, payload SHALL stay stable; rst_n pulsed low during READ byte 3 SHALL give reset output values and restart at F0(s).
REQ-033 With POLL_CYCLES=1000, consecutive data_valid pulses SHALL be exactly 1000 cycles apart in steady state.
